// File: rtl/uart_boot_loader.sv
// Boot sequencer: receives a framed image over UART, writes it to Memory, then releases the CPU.
// Latency: one memory write in the cycle after each word's last byte; cpu_resetn rises on the edge after the deciding event.
// Backpressure: none; rx bytes are single-cycle strobes and every byte is consumed the cycle it arrives.
module uart_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_WORDS = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 27_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wmask,
  input  logic        cpu_mem_rstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  output logic        cpu_resetn,
  output logic        loading,
  output logic        error
);

  // Counter only has to reach TIMEOUT-1 before WAIT_SYNC is left.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]   MAX_W   = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_WAIT_SYNC,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [1:0]    bcnt;
  logic [15:0]   len;
  logic [13:0]   word_idx;
  logic [7:0]    csum;
  logic [23:0]   asm_lo;
  logic          wr_pend;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;

  logic          is_sync;
  logic [15:0]   len_rx;
  logic          last_word;

  assign is_sync   = rx_dv && (rx_byte == SYNC_BYTE);
  assign len_rx    = {rx_byte, len[7:0]};
  // word_idx still names the word being assembled when its last byte arrives.
  assign last_word = (({2'b00, word_idx} + 16'd1) == len);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT_SYNC;
    else       state <= state_nxt;
  end

  // Next-state decode; sync takes priority over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_SYNC: begin
        if (is_sync)              state_nxt = S_LEN;
        else if (tcnt == TO_LAST) state_nxt = S_RUN;
      end
      S_LEN: begin
        if (rx_dv && bcnt[0]) begin
          if (len_rx == 16'd0)               state_nxt = S_CHECK;
          else if ({1'b0, len_rx} > MAX_W)   state_nxt = S_ERROR;
          else                               state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_dv && (bcnt == 2'd3) && last_word) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (rx_dv) state_nxt = (rx_byte == csum) ? S_RUN : S_ERROR;
      end
      S_RUN:   state_nxt = S_RUN;
      S_ERROR: begin
        if (is_sync) state_nxt = S_LEN;
      end
      default: state_nxt = S_WAIT_SYNC;
    endcase
  end

  // Frame datapath: timeout count, length capture, word assembly, checksum and write staging.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt     <= '0;
      bcnt     <= '0;
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
      asm_lo   <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) word_idx <= word_idx + 14'd1;
      if (state == S_WAIT_SYNC) tcnt <= tcnt + 1'b1;
      case (state)
        S_WAIT_SYNC, S_ERROR: begin
          if (is_sync) begin
            bcnt     <= '0;
            csum     <= '0;
            word_idx <= '0;
          end
        end
        S_LEN: begin
          if (rx_dv) begin
            if (!bcnt[0]) begin
              len[7:0] <= rx_byte;
              bcnt     <= 2'd1;
            end else begin
              len  <= len_rx;
              bcnt <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (rx_dv) begin
            csum <= csum + rx_byte;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              wr_data <= {rx_byte, asm_lo};
              wr_addr <= BASE_ADDR + {16'b0, word_idx, 2'b00};
              wr_pend <= 1'b1;
            end else begin
              asm_lo <= {rx_byte, asm_lo[23:8]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port mux: CPU passes straight through in RUN, loader owns the port otherwise.
  always_comb begin
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    mem_wmask = wr_pend ? 4'hF : 4'h0;
    mem_rstrb = 1'b0;
    if (state == S_RUN) begin
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
      mem_wmask = cpu_mem_wmask;
      mem_rstrb = cpu_mem_rstrb;
    end
  end

  assign cpu_resetn = (state == S_RUN);
  assign loading    = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
  assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames plus randomized frames against a byte-level frame model.
// Expected memory writes are queued at stimulus time and popped by an independent write monitor.
// Short TIMEOUT keeps the timeout scenarios cheap.
module tb_uart_boot_loader;

  localparam int          TO   = 100;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [31:0] cpu_mem_addr = 32'hDEAD_BEE0;
  logic [31:0] cpu_mem_wdata = 32'h1234_5678;
  logic [3:0]  cpu_mem_wmask = 4'hF;
  logic        cpu_mem_rstrb = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, cpu_resetn, loading, error;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] fw[$];

  always #5 clk = ~clk;

  uart_boot_loader #(
    .SYNC_BYTE(8'hA5),
    .MAX_WORDS(8192),
    .BASE_ADDR(BASE),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_dv(rx_dv),
    .rx_byte(rx_byte),
    .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wmask(cpu_mem_wmask),
    .cpu_mem_rstrb(cpu_mem_rstrb),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .cpu_resetn(cpu_resetn),
    .loading(loading),
    .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: any loader write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && !cpu_resetn && mem_wmask != 4'h0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr=%h data=%h wmask=%h, expected no write",
                 mem_addr, mem_wdata, mem_wmask);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
        chk("wr_mask", {28'h0, mem_wmask}, 32'hF);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_dv = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
    repeat ($urandom_range(0, maxgap)) tick();
  endtask

  // Reference frame: sync, LEN little-endian, words little-endian, 8-bit sum of data bytes.
  task automatic send_frame(input int n, input logic [7:0] cs_xor, input int gap);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] w;
    sum = 8'h00;
    send_byte(8'hA5, gap);
    chk("sync_loading", loading, 1);
    chk("sync_error", error, 0);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      exp_q.push_back(wr_t'{addr: BASE + 32'(4 * i), data: w});
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        sum = sum + b;
        send_byte(b, gap);
      end
    end
    chk("pre_cs_resetn", cpu_resetn, 0);
    chk("pre_cs_loading", loading, 1);
    send_byte(sum ^ cs_xor, 0);
  endtask

  task automatic check_outcome(input bit good);
    chk("out_resetn", cpu_resetn, good);
    chk("out_error", error, !good);
    chk("out_loading", loading, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  // Count cycles from reset release; a stray non-sync byte must not disturb the timeout.
  task automatic timeout_run(input bit stray);
    for (int c = 0; c <= TO; c++) begin
      if (stray && c == 10) begin
        rx_dv   = 1'b1;
        rx_byte = 8'h55;
      end else begin
        rx_dv = 1'b0;
      end
      if (c == TO - 1) chk("to_before", cpu_resetn, 0);
      if (c == TO)     chk("to_at", cpu_resetn, 1);
      tick();
    end
    rx_dv = 1'b0;
  endtask

  initial begin
    int n;
    bit bad;
    logic [7:0] x;
    logic [31:0] wd;

    // Reset state, CPU bus driven active but ignored.
    do_reset();
    chk("rst_resetn", cpu_resetn, 0);
    chk("rst_loading", loading, 0);
    chk("rst_error", error, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_rstrb", mem_rstrb, 0);

    // Directed two-word frame, back-to-back bytes.
    fw.delete();
    fw.push_back(32'h0000_0013);
    fw.push_back(32'h0000_006F);
    send_frame(2, 8'h00, 0);
    check_outcome(1);
    // RUN pass-through, rx ignored.
    wd = $urandom;
    cpu_mem_addr  = 32'h8;
    cpu_mem_wdata = wd;
    cpu_mem_wmask = 4'h3;
    cpu_mem_rstrb = 1'b1;
    rx_dv   = 1'b1;
    rx_byte = 8'hA5;
    #1;
    chk("run_rstrb", mem_rstrb, 1);
    chk("run_addr", mem_addr, 32'h8);
    chk("run_wdata", mem_wdata, wd);
    chk("run_wmask", mem_wmask, 4'h3);
    tick();
    rx_dv = 1'b0;
    chk("run_stay", cpu_resetn, 1);
    chk("run_noload", loading, 0);
    cpu_mem_addr  = 32'hDEAD_BEE0;
    cpu_mem_wmask = 4'hF;

    // Bad checksum 0x83, no timeout in ERROR, then recovery by resend.
    do_reset();
    send_frame(2, 8'h01, 0);
    check_outcome(0);
    repeat (TO + 20) tick();
    chk("err_hold", error, 1);
    chk("err_cpu_held", cpu_resetn, 0);
    send_frame(2, 8'h00, 1);
    check_outcome(1);

    // Timeout with a stray non-sync byte.
    do_reset();
    timeout_run(1'b1);

    // LEN above MAX_WORDS, then empty frame from ERROR.
    do_reset();
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    send_byte(8'h20, 0);
    chk("len_big_err", error, 1);
    chk("len_big_load", loading, 0);
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    chk("len0_check", loading, 1);
    send_byte(8'h00, 0);
    chk("len0_run", cpu_resetn, 1);
    chk("len0_err", error, 0);

    // Reset mid-frame after five data bytes.
    do_reset();
    fw.delete();
    fw.push_back($urandom);
    send_byte(8'hA5, 1);
    send_byte(8'h03, 1);
    send_byte(8'h00, 1);
    exp_q.push_back(wr_t'{addr: BASE, data: fw[0]});
    for (int k = 0; k < 4; k++) begin
      wd = fw[0];
      send_byte(wd[8*k +: 8], 1);
    end
    send_byte(8'h77, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_resetn", cpu_resetn, 0);
    chk("mid_rst_loading", loading, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_drain", exp_q.size(), 0);
    timeout_run(1'b0);

    // Randomized frames, some with corrupted checksum followed by a good resend.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(1, 6);
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom);
      bad = ($urandom_range(0, 2) == 0);
      x = bad ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(n, x, 3);
      check_outcome(!bad);
      if (bad) begin
        n = $urandom_range(1, 6);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom);
        send_frame(n, 8'h00, 2);
        check_outcome(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
